// File: rtl/dm_pkg.sv
// ============================================================================
// Module : dm_pkg
// Brief  : Size encodings, FSM state type and alignment check for the
//          load/store front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_RD  = 3'd1,
        ST_STORE_RD = 3'd2,
        ST_STORE_WR = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // A reserved size is folded in so one call covers every error case.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module : mem_lane_align
// Brief  : Little-endian lane select/extend for loads and lane merge for
//          sub-word stores (purely combinational, 32-bit only).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bshift;
    logic [31:0] w_hshift;

    assign w_bsh    = {i_offset, 3'b000};
    assign w_hsh    = {i_offset[1], 4'b0000};
    assign w_bshift = i_word >> w_bsh;
    assign w_hshift = i_word >> w_hsh;
    assign w_byte   = w_bshift[7:0];
    assign w_half   = w_hshift[15:0];

    always_comb begin
        o_load   = 32'h0;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load   = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_merged = (i_word & ~(32'h0000_00FF << w_bsh))
                         | ({24'h0, i_wdata[7:0]} << w_bsh);
            end
            SZ_HALF: begin
                o_load   = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_merged = (i_word & ~(32'h0000_FFFF << w_hsh))
                         | ({16'h0, i_wdata[15:0]} << w_hsh);
            end
            SZ_WORD: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
            default: begin
                o_load   = 32'h0;
                o_merged = i_word;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Load/store front end for a word-indexed DATAMEMORY with
//          read-modify-write sub-word stores and a valid/ready handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import dm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWdata,
    output logic              respValid,
    output logic [DATA_W-1:0] respData,
    output logic              respError,
    output logic [ADDR_W-1:0] memAddress,
    output logic              memRead,
    output logic              memWrite,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData
);

    state_t            r_state;
    logic [1:0]        r_size;
    logic [1:0]        r_offset;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    // Strobes decode straight from the state register so a reset drops them at once.
    assign reqReady  = (r_state == ST_IDLE);
    assign respValid = (r_state == ST_RESP);
    assign memRead   = (r_state == ST_LOAD_RD) || (r_state == ST_STORE_RD);
    assign memWrite  = (r_state == ST_STORE_WR);

    mem_lane_align u_align (
        .i_word     (memReadData),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_size       <= SZ_BYTE;
            r_offset     <= 2'b00;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            memAddress   <= '0;
            memWriteData <= '0;
            respData     <= '0;
            respError    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (reqValid) begin
                        r_size     <= reqSize;
                        r_offset   <= reqAddr[1:0];
                        r_unsigned <= reqUnsigned;
                        r_wdata    <= reqWdata;
                        memAddress <= {2'b00, reqAddr[ADDR_W-1:2]};
                        if (misaligned(reqSize, reqAddr[1:0])) begin
                            respError <= 1'b1;
                            respData  <= '0;
                            r_state   <= ST_RESP;
                        end else if (!reqWrite) begin
                            r_state <= ST_LOAD_RD;
                        end else if (reqSize == SZ_WORD) begin
                            memWriteData <= reqWdata;
                            r_state      <= ST_STORE_WR;
                        end else begin
                            r_state <= ST_STORE_RD;
                        end
                    end
                end
                ST_LOAD_RD: begin
                    respData  <= w_load;
                    respError <= 1'b0;
                    r_state   <= ST_RESP;
                end
                ST_STORE_RD: begin
                    memWriteData <= w_merged;
                    r_state      <= ST_STORE_WR;
                end
                ST_STORE_WR: begin
                    respData  <= '0;
                    respError <= 1'b0;
                    r_state   <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed self-checking bench with a small DATAMEMORY model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic [31:0] memAddress;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    logic [31:0] dmem [0:3];

    int ncmp  = 0;
    int nfail = 0;

    int          t_lat;
    int          t_rd;
    int          t_wr;
    logic [31:0] t_wd;
    logic [31:0] t_ma;
    int          seen;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqSize      (reqSize),
        .reqUnsigned  (reqUnsigned),
        .reqAddr      (reqAddr),
        .reqWdata     (reqWdata),
        .respValid    (respValid),
        .respData     (respData),
        .respError    (respError),
        .memAddress   (memAddress),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    assign memReadData = dmem[memAddress[1:0]];

    always @(posedge clk) begin
        if (memWrite) dmem[memAddress[1:0]] <= memWriteData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from an IDLE cycle and track strobes until respValid.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u;
        reqAddr = a; reqWdata = d;
        check("ready_before_accept", {31'h0, reqReady}, 32'h1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        t_lat = 0; t_rd = 0; t_wr = 0; t_wd = 32'h0; t_ma = memAddress;
        for (int k = 1; k <= 8; k++) begin
            if (memRead) t_rd++;
            if (memWrite) begin t_wr++; t_wd = memWriteData; end
            if (respValid) begin t_lat = k; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        dmem[0] = 32'h8899AABB; dmem[1] = 32'h11223344;
        dmem[2] = 32'h0;        dmem[3] = 32'h0;
        rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqUnsigned = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'h0, reqReady},  32'h1);
        check("rst_rvalid", {31'h0, respValid}, 32'h0);
        check("rst_rdata",  respData,           32'h0);
        check("rst_rerr",   {31'h0, respError}, 32'h0);
        check("rst_mrd",    {31'h0, memRead},   32'h0);
        check("rst_mwr",    {31'h0, memWrite},  32'h0);
        check("rst_maddr",  memAddress,         32'h0);
        check("rst_mwdata", memWriteData,       32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
        check("lb_maddr", t_ma, 32'h0);
        check("lb_lat",   t_lat, 32'd2);
        check("lb_data",  respData, 32'hFFFFFFAA);
        run_op(1'b0, 2'b00, 1'b1, 32'h1, 32'h0);
        check("lbu_data", respData, 32'h000000AA);

        run_op(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        check("lh6_maddr", t_ma, 32'h1);
        check("lh6_data",  respData, 32'h00001122);
        run_op(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        check("lh2_data", respData, 32'hFFFF8899);
        run_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check("lw4_data", respData, 32'h11223344);
        check("lw4_err",  {31'h0, respError}, 32'h0);

        run_op(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000EE);
        check("sb_reads",  t_rd,  32'd1);
        check("sb_writes", t_wr,  32'd1);
        check("sb_wdata",  t_wd,  32'h1122EE44);
        check("sb_lat",    t_lat, 32'd3);
        check("sb_rdata",  respData, 32'h0);
        check("sb_mem1",   dmem[1], 32'h1122EE44);
        run_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check("lw_after_sb", respData, 32'h1122EE44);

        run_op(1'b0, 2'b10, 1'b0, 32'h3, 32'h0);
        check("lw3_err",    {31'h0, respError}, 32'h1);
        check("lw3_data",   respData, 32'h0);
        check("lw3_strobe", t_rd + t_wr, 32'd0);
        check("lw3_lat",    t_lat, 32'd1);
        run_op(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
        check("lh_ok_err",  {31'h0, respError}, 32'h0);
        run_op(1'b1, 2'b11, 1'b0, 32'h8, 32'h12345678);
        check("rsvd_err",    {31'h0, respError}, 32'h1);
        check("rsvd_data",   respData, 32'h0);
        check("rsvd_strobe", t_rd + t_wr, 32'd0);
        check("rsvd_lat",    t_lat, 32'd1);
        check("rsvd_mem2",   dmem[2], 32'h0);

        // Reset in the middle of a word store.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddr = 32'h0; reqWdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        reqValid = 1'b0;
        check("sw_mwr_high", {31'h0, memWrite}, 32'h1);
        check("sw_mwdata",   memWriteData, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mwr_drop", {31'h0, memWrite}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (respValid) seen++;
        end
        check("abort_no_resp", seen, 32'd0);
        check("abort_ready",   {31'h0, reqReady}, 32'h1);
        check("abort_mem0",    dmem[0], 32'h8899AABB);

        // Back-to-back loads with reqValid held high.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddr = 32'h4; reqWdata = 32'h0;
        @(posedge clk); #1;
        reqAddr = 32'h0;
        check("b2b_busy1",  {31'h0, reqReady}, 32'h0);
        @(posedge clk); #1;
        check("b2b_resp1",  {31'h0, respValid}, 32'h1);
        check("b2b_data1",  respData, 32'h1122EE44);
        check("b2b_busy2",  {31'h0, reqReady}, 32'h0);
        @(posedge clk); #1;
        check("b2b_idle",   {31'h0, reqReady}, 32'h1);
        check("b2b_gap",    {31'h0, respValid}, 32'h0);
        @(posedge clk); #1;
        reqValid = 1'b0;
        check("b2b_rd2",    {31'h0, memRead}, 32'h1);
        check("b2b_maddr2", memAddress, 32'h0);
        @(posedge clk); #1;
        check("b2b_resp2",  {31'h0, respValid}, 32'h1);
        check("b2b_data2",  respData, 32'h8899AABB);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
